// File: rtl/png_enc_seq.sv
// -----------------------------------------------------------------------------
// png_enc_seq - frame sequencer for the PNG encoder pipeline.
//
// Queues per-frame {width, height} commands and presents the active frame size
// on cfg_w_o/cfg_h_o. It pulses start_o to filter/adler32/bs/crc32 and pulses
// lz77_start_o once the filter is done. It reports output length and a frame
// count when the bitstream stage finishes.
//
// Optional feature macro: PNG_ENC_SEQ_WDT_EN
//   When defined, an idle watchdog of WDT_CYC cycles aborts a stalled frame.
//   The frame is then reported with frm_err_o = 1.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cmd_val_i/cmd_rdy_o       command handshake (rdy = queue not full)
//   cmd_w_i, cmd_h_i          command frame width / height
//   cfg_w_o, cfg_h_o          active frame size, stable from pop to done
//   start_o                   one-cycle start to filter, adler32, bs, crc32
//   flt_done_i                filter done pulse
//   lz77_start_o              one-cycle lz77 start, one cycle after flt_done_i
//   bs_val_i, bs_done_i       bitstream word valid / bitstream done pulse
//   busy_o                    a frame is in progress
//   frm_done_o, frm_err_o     frame-complete pulse, abort qualifier
//   frm_len_o                 output words of the last frame (saturating)
//   frm_cnt_o                 completed frame count (wraps)
// -----------------------------------------------------------------------------
module png_enc_seq #(
    parameter int CMD_DEPTH = 4,
    parameter int W_WD      = 16,
    parameter int H_WD      = 16,
    parameter int CNT_WD    = 24,
    parameter int WDT_CYC   = 65535
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_val_i,
    output logic              cmd_rdy_o,
    input  logic [W_WD-1:0]   cmd_w_i,
    input  logic [H_WD-1:0]   cmd_h_i,
    output logic [W_WD-1:0]   cfg_w_o,
    output logic [H_WD-1:0]   cfg_h_o,
    output logic              start_o,
    input  logic              flt_done_i,
    output logic              lz77_start_o,
    input  logic              bs_val_i,
    input  logic              bs_done_i,
    output logic              busy_o,
    output logic              frm_done_o,
    output logic              frm_err_o,
    output logic [CNT_WD-1:0] frm_len_o,
    output logic [15:0]       frm_cnt_o
);

    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = W_WD + H_WD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FLT,
        S_LZ,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     mem [CMD_DEPTH];
    logic [CW-1:0]     head;
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, push, pop;
    logic              active, abort, to_err, err_q;
    logic [CNT_WD-1:0] word_cnt, word_nxt;

    // ---------------------------------------------------------------- queue
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_rdy_o = !full;
    assign push      = cmd_val_i && !full;
    assign pop       = (state == S_IDLE) && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];

    // NOTE: queue storage has no reset; the pointers alone define which
    // entries are valid, so clearing them empties the queue.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_w_i, cmd_h_i};
        end
    end

    // ------------------------------------------------------------- watchdog
    assign active = (state == S_FLT) || (state == S_LZ);

`ifdef PNG_ENC_SEQ_WDT_EN
    localparam int WDT_WD = $clog2(WDT_CYC + 1);

    logic [WDT_WD-1:0] wdt_cnt;
    logic              wdt_clr;

    assign wdt_clr = start_o || flt_done_i || bs_val_i;
    // Abort on the cycle the counter would reach WDT_CYC without activity.
    assign abort   = active && !wdt_clr && (wdt_cnt == WDT_WD'(WDT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdt_cnt <= '0;
        end else if (wdt_clr) begin
            wdt_cnt <= '0;
        end else if (active) begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end
`else
    logic unused_wdt;

    assign abort      = 1'b0;
    assign unused_wdt = (WDT_CYC != 0);
`endif

    // ------------------------------------------------------------------ fsm
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path
        // through the case statement can leave a latch behind.
        state_nxt = state;
        to_err    = 1'b0;
        case (state)
            S_IDLE:  if (!empty) state_nxt = S_START;
            S_START: state_nxt = S_FLT;
            S_FLT: begin
                if (abort) begin
                    state_nxt = S_DONE;
                    to_err    = 1'b1;
                end else if (flt_done_i) begin
                    state_nxt = S_LZ;
                end
            end
            S_LZ: begin
                // A genuine bs_done_i wins over a coincident watchdog abort.
                if (bs_done_i) begin
                    state_nxt = S_DONE;
                end else if (abort) begin
                    state_nxt = S_DONE;
                    to_err    = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The word that arrives together with bs_done_i still counts, so the
    // reported length uses the next-value of the counter.
    assign word_nxt = (active && bs_val_i && (word_cnt != {CNT_WD{1'b1}}))
                    ? word_cnt + CNT_WD'(1) : word_cnt;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cfg_w_o      <= '0;
            cfg_h_o      <= '0;
            start_o      <= 1'b0;
            lz77_start_o <= 1'b0;
            word_cnt     <= '0;
            frm_len_o    <= '0;
            frm_cnt_o    <= '0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            start_o      <= (state == S_START);
            lz77_start_o <= (state == S_FLT) && (state_nxt == S_LZ);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                cfg_w_o  <= head[CW-1:H_WD];
                cfg_h_o  <= head[H_WD-1:0];
                word_cnt <= '0;
            end else begin
                word_cnt <= word_nxt;
            end
            if (state_nxt == S_DONE) begin
                frm_len_o <= word_nxt;
                frm_cnt_o <= frm_cnt_o + 16'd1;
                err_q     <= to_err;
            end
        end
    end

    assign busy_o     = (state != S_IDLE);
    assign frm_done_o = (state == S_DONE);
    assign frm_err_o  = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_png_enc_seq.sv
// -----------------------------------------------------------------------------
// tb_png_enc_seq - self-checking bench for png_enc_seq.
//
// Expected per-frame results {w, h, len, err} are queued when a command is
// pushed. They are popped and compared when frm_done_o is seen. Directed
// steps also check latencies, queue-full, saturation and mid-frame reset.
// When PNG_ENC_SEQ_WDT_EN is defined, the watchdog abort is also exercised.
// -----------------------------------------------------------------------------
module tb_png_enc_seq;

    localparam int W_WD    = 8;
    localparam int H_WD    = 8;
    localparam int CNT_WD  = 4;
    localparam int DEPTH   = 4;
    localparam int WDT_CYC = 100;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cmd_val = 1'b0;
    logic              cmd_rdy_o;
    logic [W_WD-1:0]   cmd_w = '0;
    logic [H_WD-1:0]   cmd_h = '0;
    logic [W_WD-1:0]   cfg_w_o;
    logic [H_WD-1:0]   cfg_h_o;
    logic              start_o;
    logic              flt_done = 1'b0;
    logic              lz77_start_o;
    logic              bs_val = 1'b0;
    logic              bs_done = 1'b0;
    logic              busy_o;
    logic              frm_done_o;
    logic              frm_err_o;
    logic [CNT_WD-1:0] frm_len_o;
    logic [15:0]       frm_cnt_o;

    always #5 clk = ~clk;

    png_enc_seq #(
        .CMD_DEPTH(DEPTH),
        .W_WD     (W_WD),
        .H_WD     (H_WD),
        .CNT_WD   (CNT_WD),
        .WDT_CYC  (WDT_CYC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_val_i   (cmd_val),
        .cmd_rdy_o   (cmd_rdy_o),
        .cmd_w_i     (cmd_w),
        .cmd_h_i     (cmd_h),
        .cfg_w_o     (cfg_w_o),
        .cfg_h_o     (cfg_h_o),
        .start_o     (start_o),
        .flt_done_i  (flt_done),
        .lz77_start_o(lz77_start_o),
        .bs_val_i    (bs_val),
        .bs_done_i   (bs_done),
        .busy_o      (busy_o),
        .frm_done_o  (frm_done_o),
        .frm_err_o   (frm_err_o),
        .frm_len_o   (frm_len_o),
        .frm_cnt_o   (frm_cnt_o)
    );

    typedef struct packed {
        logic [W_WD-1:0]   w;
        logic [H_WD-1:0]   h;
        logic [CNT_WD-1:0] len;
        logic              err;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] exp_frames = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [W_WD-1:0] w, input logic [H_WD-1:0] h,
                            input logic [CNT_WD-1:0] len, input logic err);
        exp_t e;
        check("cmd_rdy", cmd_rdy_o, 1);
        e.w = w; e.h = h; e.len = len; e.err = err;
        sb.push_back(e);
        cmd_val = 1'b1;
        cmd_w   = w;
        cmd_h   = h;
        tick();
        cmd_val = 1'b0;
    endtask

    // Returns at the falling edge inside the start_o cycle.
    task automatic wait_start(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = start_o;
        end
        check(tag, seen, 1);
    endtask

    // Drives one frame from the start_o cycle through frm_done_o.
    task automatic run_frame(input int idle, input int words, input bit val_at_done,
                             input bit flt_in_lz, input logic [CNT_WD-1:0] len);
        tick();
        repeat (idle) tick();
        flt_done = 1'b1;
        @(negedge clk);
        check("lz77_early", lz77_start_o, 0);
        tick();
        flt_done = 1'b0;
        @(negedge clk);
        check("lz77_start", lz77_start_o, 1);
        if (flt_in_lz) begin
            tick();
            flt_done = 1'b1;
            tick();
            flt_done = 1'b0;
            @(negedge clk);
            check("lz77_repeat", lz77_start_o, 0);
        end
        tick();
        bs_val = 1'b1;
        repeat (words) tick();
        bs_val  = val_at_done;
        bs_done = 1'b1;
        @(negedge clk);
        check("done_early", frm_done_o, 0);
        tick();
        bs_done = 1'b0;
        bs_val  = 1'b0;
        @(negedge clk);
        check("frm_done", frm_done_o, 1);
        @(negedge clk);
        check("done_pulse", frm_done_o, 0);
        check("len_held", frm_len_o, len);
    endtask

    // Scoreboard side: every completed frame is matched against its command.
    always @(negedge clk) begin
        if (rstn && frm_done_o) begin
            if (sb.size() == 0) begin
                check("unexpected_done", frm_done_o, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                exp_frames = exp_frames + 16'd1;
                check("done_cfg_w", cfg_w_o, e.w);
                check("done_cfg_h", cfg_h_o, e.h);
                check("frm_len", frm_len_o, e.len);
                check("frm_err", frm_err_o, e.err);
                check("frm_cnt", frm_cnt_o, exp_frames);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic flag;
        int   n;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_rdy", cmd_rdy_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_start", start_o, 0);
        check("rst_cfg_w", cfg_w_o, 0);
        check("rst_len", frm_len_o, 0);
        check("rst_cnt", frm_cnt_o, 0);
        rstn = 1'b1;
        tick();

        // Single frame: start latency, cfg ahead of start, 5 words
        push_cmd(8'd4, 8'd2, 4'd5, 1'b0);
        @(negedge clk);
        check("start_lat0", start_o, 0);
        @(negedge clk);
        check("start_lat1", start_o, 0);
        check("cfg_w_pre", cfg_w_o, 4);
        check("cfg_h_pre", cfg_h_o, 2);
        @(negedge clk);
        check("start_at_2", start_o, 1);
        run_frame(8, 5, 1'b0, 1'b0, 4'd5);
        check("frm_cnt_first", frm_cnt_o, 1);

        // Fill the queue while a frame is busy
        push_cmd(8'd1, 8'd1, 4'd3, 1'b0);
        wait_start("start_a");
        push_cmd(8'd10, 8'd20, 4'd2, 1'b0);
        push_cmd(8'd11, 8'd21, 4'd4, 1'b0);
        push_cmd(8'd12, 8'd22, 4'd15, 1'b0);
        push_cmd(8'd13, 8'd23, 4'd1, 1'b0);
        check("rdy_full", cmd_rdy_o, 0);
        run_frame(1, 3, 1'b0, 1'b0, 4'd3);

        wait_start("start_b");
        check("cfg_w_b", cfg_w_o, 10);
        check("cfg_h_b", cfg_h_o, 20);
        check("rdy_after_pop", cmd_rdy_o, 1);
        run_frame(2, 2, 1'b0, 1'b0, 4'd2);

        // Word with bs_done counted; flt_done in LZ ignored
        wait_start("start_c");
        check("cfg_w_c", cfg_w_o, 11);
        run_frame(1, 3, 1'b1, 1'b1, 4'd4);

        // Counter saturation: 17 words into a 4-bit counter
        wait_start("start_d");
        check("cfg_h_d", cfg_h_o, 22);
        run_frame(0, 17, 1'b0, 1'b0, 4'd15);

        // Only the word coincident with bs_done
        wait_start("start_e");
        check("cfg_w_e", cfg_w_o, 13);
        run_frame(3, 0, 1'b1, 1'b0, 4'd1);

        // Reset in mid-LZ with two queued commands
        push_cmd(8'd5, 8'd5, 4'd0, 1'b0);
        wait_start("start_f");
        push_cmd(8'd6, 8'd6, 4'd0, 1'b0);
        push_cmd(8'd7, 8'd7, 4'd0, 1'b0);
        flt_done = 1'b1;
        tick();
        flt_done = 1'b0;
        bs_val   = 1'b1;
        tick();
        tick();
        bs_val = 1'b0;
        @(negedge clk);
        check("busy_lz", busy_o, 1);
        rstn = 1'b0;
        #1;
        sb.delete();
        exp_frames = '0;
        check("arst_busy", busy_o, 0);
        check("arst_rdy", cmd_rdy_o, 1);
        check("arst_done", frm_done_o, 0);
        check("arst_cfg_w", cfg_w_o, 0);
        check("arst_cfg_h", cfg_h_o, 0);
        check("arst_len", frm_len_o, 0);
        check("arst_cnt", frm_cnt_o, 0);
        check("arst_lz77", lz77_start_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            flag = flag | start_o | busy_o | frm_done_o;
        end
        check("no_start_after_rst", flag, 0);

`ifdef PNG_ENC_SEQ_WDT_EN
        // Watchdog abort, then the next queued frame runs normally
        push_cmd(8'd9, 8'd9, 4'd0, 1'b1);
        push_cmd(8'd3, 8'd3, 4'd2, 1'b0);
        wait_start("start_wdt");
        n    = 0;
        flag = 1'b0;
        for (int i = 0; i < 300 && !flag; i++) begin
            @(negedge clk);
            n++;
            flag = frm_done_o;
        end
        check("wdt_cycles", n, 101);
        wait_start("start_after_wdt");
        check("cfg_w_after_wdt", cfg_w_o, 3);
        run_frame(2, 2, 1'b0, 1'b0, 4'd2);
`else
        n = 0;
`endif

        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
